// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling ticks, helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned OVERSAMPLE     = 8;
    localparam logic [2:0]  SAMPLE_TICK_LO  = 3'd3;
    localparam logic [2:0]  SAMPLE_TICK_MID = 3'd4;
    localparam logic [2:0]  SAMPLE_TICK_HI  = 3'd5;
    localparam logic [2:0]  DECIDE_TICK     = 3'd5;
    localparam logic [2:0]  LAST_TICK       = 3'(OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Counter reload value; a prescale of 0 behaves like 1.
    function automatic logic [15:0] tick_reload(input logic [15:0] p);
        return (p == 16'd0) ? 16'd0 : p - 16'd1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one tick every P clocks, 3-bit tick index, restartable.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        restart_i,
    input  logic [15:0] prescale_i,
    output logic        tick_o,
    output logic [2:0]  tick_idx_o
);

    logic [15:0] prescale_q, prescale_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;

    assign tick_o     = (cnt_q == 16'd0);
    assign tick_idx_o = idx_q;

    always_comb begin
        prescale_d = prescale_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        if (restart_i) begin
            prescale_d = prescale_i;
            cnt_d      = tick_reload(prescale_i);
            idx_d      = 3'd0;
        end else if (tick_o) begin
            cnt_d = tick_reload(prescale_q);
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prescale_q <= 16'd0;
            cnt_q      <= 16'd0;
            idx_q      <= 3'd0;
        end else begin
            prescale_q <= prescale_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
        end
    end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver presenting bytes on an AXI-stream master with overrun/frame error pulses.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  rxd_i,
    input  logic [15:0]           prescale_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  busy_o,
    output logic                  overrun_error_o,
    output logic                  frame_error_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_error_o
`endif
);

    logic sync1_q, sync2_q, rx_prev_q;
    logic rx_s, fall, restart, tick, maj, decide, last, word_done, par_bad;
    logic [2:0] tidx;

    uart_state_e           state_q;
    logic                  s3_q, s4_q;
    logic [3:0]            bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q, tdata_q;
    logic                  tvalid_q, overrun_q, frame_err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rxd_i;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_s    = sync2_q;
    assign fall    = rx_prev_q & ~rx_s;
    assign restart = (state_q == StIdle) && fall;

    uart_baud_tick u_baud_tick (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .restart_i  (restart),
        .prescale_i (prescale_i),
        .tick_o     (tick),
        .tick_idx_o (tidx)
    );

    assign maj       = majority3(s3_q, s4_q, rx_s);
    assign decide    = tick && (tidx == DECIDE_TICK);
    assign last      = tick && (tidx == LAST_TICK);
    assign word_done = (state_q == StStop) && decide && maj && !par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_err_q;
    assign par_bad        = par_bad_q;
    assign parity_error_o = par_err_q;
`else
    logic unused_parity_odd;
    assign par_bad           = 1'b0;
    assign unused_parity_odd = PARITY_ODD;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            s3_q        <= 1'b1;
            s4_q        <= 1'b1;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            if (tick && (tidx == SAMPLE_TICK_LO)) s3_q <= rx_s;
            if (tick && (tidx == SAMPLE_TICK_MID)) s4_q <= rx_s;

            case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_q <= StStart;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (decide && maj) begin
                        state_q <= StIdle;
                    end else if (last) begin
                        state_q   <= StData;
                        bit_cnt_q <= 4'd0;
                    end
                end
                StData: begin
                    if (decide) shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
                    if (last) begin
                        if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (decide && ((^shift_q ^ maj) != PARITY_ODD)) begin
                        par_bad_q <= 1'b1;
                        par_err_q <= 1'b1;
                    end
                    if (last) state_q <= StStop;
                end
`endif
                StStop: begin
                    // Leave on the decision tick so a back-to-back start bit is caught.
                    if (decide) begin
                        state_q <= StIdle;
                        if (!maj) frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (word_done) begin
                if (!tvalid_q || m_axis_tready_i) begin
                    tdata_q  <= shift_q;
                    tvalid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (tvalid_q && m_axis_tready_i) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign busy_o          = (state_q != StIdle);
    assign overrun_error_o = overrun_q;
    assign frame_error_o   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed scoreboard bench for uart_rx_axis (8-bit words, optional UART_RX_PARITY_EN build).
module tb_uart_rx_axis;

`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] prescale = 16'd4;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        busy;
    logic        ovr;
    logic        ferr;
`ifdef UART_RX_PARITY_EN
    logic        perr;
`else
    logic        par_unused;
`endif

    uart_rx_axis #(.DATA_WIDTH(8), .PARITY_ODD(1'b0)) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .rxd_i           (rxd),
        .prescale_i      (prescale),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .busy_o          (busy),
        .overrun_error_o (ovr),
        .frame_error_o   (ferr)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error_o  (perr)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records accepted words, error pulses and tvalid timing.
    logic [7:0] got_q[$];
    int rise_cnt = 0, rise_cyc = 0, hi_len = 0, ovr_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    logic tv_prev = 1'b0;
    always @(negedge clk) begin
        if (tvalid && !tv_prev) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (!tvalid && tv_prev) hi_len <= cyc - rise_cyc;
        if (tvalid && tready) got_q.push_back(tdata);
        if (ovr) ovr_cnt <= ovr_cnt + 1;
        if (ferr) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (perr) perr_cnt <= perr_cnt + 1;
`endif
        tv_prev <= tvalid;
    end

    int checks = 0, failures = 0;
    int fall_cyc = 0, got_rd = 0;
    logic [7:0] exp_q[$];
    int base_rise, base_ovr, base_ferr, base_perr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_words(input string tag);
        check({tag, "_count"}, got_q.size() - got_rd, exp_q.size());
        while (got_rd < got_q.size() && exp_q.size() > 0) begin
            check({tag, "_data"}, {24'd0, got_q[got_rd]}, {24'd0, exp_q.pop_front()});
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    function automatic int latency(input int p);
        return ((8 + 1 + PAR) * 8 + 6) * ((p == 0) ? 1 : p) + 3;
    endfunction

    task automatic snap();
        base_rise = rise_cnt;
        base_ovr  = ovr_cnt;
        base_ferr = ferr_cnt;
        base_perr = perr_cnt;
    endtask

    // Entered and left at posedge+1 so consecutive frames abut exactly.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int p);
        int n;
        n = 8 * ((p == 0) ? 1 : p);
        prescale = p[15:0];
        fall_cyc = cyc;
        rxd = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (n) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        repeat (n) @(posedge clk);
        #1;
`else
        par_unused = par;
`endif
        rxd = stop;
        repeat (n) @(posedge clk);
        #1;
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        check("rst_ferr", ferr, 0);
        rstn = 1'b1;
        tready = 1'b1;
        idle(5);

        // Single word, tready high
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 4);
        idle(10);
        check("a5_rises", rise_cnt - base_rise, 1);
        check("a5_latency", rise_cyc - fall_cyc, latency(4));
        check("a5_hi_len", hi_len, 1);
        check("a5_errs", (ovr_cnt - base_ovr) + (ferr_cnt - base_ferr), 0);
        cmp_words("a5");

        // Back-to-back words with tready low: second word overruns
        snap();
        tready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, 4);
        send_frame(8'hC3, 1'b0, 1'b1, 4);
        idle(10);
        check("ovr_tvalid", tvalid, 1);
        check("ovr_tdata", tdata, 8'h3C);
        check("ovr_pulses", ovr_cnt - base_ovr, 1);
        check("ovr_ferr", ferr_cnt - base_ferr, 0);
        tready = 1'b1;
        idle(1);
        check("ovr_drain_tvalid", tvalid, 0);
        cmp_words("ovr");

        // Start glitch
        snap();
        rxd = 1'b0;
        idle(8);
        rxd = 1'b1;
        idle(4);
        check("glitch_busy_mid", busy, 1);
        idle(18);
        check("glitch_busy_end", busy, 0);
        check("glitch_rises", rise_cnt - base_rise, 0);
        check("glitch_errs", (ovr_cnt - base_ovr) + (ferr_cnt - base_ferr), 0);

        // Stop bit low, then a good frame
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 4);
        idle(10);
        check("ferr_pulses", ferr_cnt - base_ferr, 1);
        check("ferr_rises", rise_cnt - base_rise, 0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b1, 4);
        idle(10);
        check("ferr_after_pulses", ferr_cnt - base_ferr, 1);
        cmp_words("after_ferr");

        // Prescale 0 behaves as 1
        snap();
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        idle(5);
        check("p0_latency", rise_cyc - fall_cyc, latency(0));
        check("p0_rises", rise_cnt - base_rise, 1);
        cmp_words("p0");

        // Reset in the middle of a frame
        snap();
        prescale = 16'd4;
        rxd = 1'b0;
        idle(40);
        rxd = 1'b1;
        idle(10);
        check("mid_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_tdata", tdata, 0);
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_errs", {30'd0, ovr, ferr}, 0);
        idle(3);
        rstn = 1'b1;
        idle(100);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1, 4);
        idle(10);
        check("mid_no_ferr", ferr_cnt - base_ferr, 0);
        cmp_words("after_rst");

`ifdef UART_RX_PARITY_EN
        snap();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 4);
        idle(10);
        check("par_ok_perr", perr_cnt - base_perr, 0);
        cmp_words("par_ok");
        snap();
        send_frame(8'h07, 1'b0, 1'b1, 4);
        idle(10);
        check("par_bad_perr", perr_cnt - base_perr, 1);
        check("par_bad_rises", rise_cnt - base_rise, 0);
        check("par_bad_ferr", ferr_cnt - base_ferr, 0);
`endif

        check("final_words", got_q.size() - got_rd, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
